// File: rtl/moving_sum_decoder_if.sv
// Valid/ready stream bundle for moving_sum_decoder: sum words in, samples out.
// master: upstream/downstream side (drives sums, accepts samples).
// slave: the decoder itself.
interface moving_sum_decoder_if #(
  parameter int unsigned n          = 3,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + n;

  logic                         s_valid;
  logic                         s_ready;
  logic signed [ACC_WIDTH-1:0]  s_sum;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_sum, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_sum, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/moving_sum_decoder.sv
// Inverse boxcar filter: rebuilds x[k] = S[k] - S[k-1] + x[k-N] from N-sample running sums.
// Single output register, 1-cycle latency, full-throughput valid/ready on both sides.
// Optional: define MOVING_SUM_DECODER_SAT_EN to saturate out-of-range samples instead of
// wrapping them (err is raised either way).
module moving_sum_decoder #(
  parameter int unsigned n          = 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  moving_sum_decoder_if.slave bus,
  output logic                primed,
  output logic                err
);

  localparam int unsigned N         = 1 << n;
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + n;
  localparam int unsigned DIFF_W    = ACC_WIDTH + 2;
  localparam int unsigned HI_W      = DIFF_W - DATA_WIDTH + 1;
  localparam logic [n:0]  LastCount = (n + 1)'(N - 1);

  typedef enum logic [0:0] {StWarmup, StSteady} state_e;

  state_e                       state_q, state_d;
  logic [n:0]                   count_q, count_d;
  logic signed [ACC_WIDTH-1:0]  prev_q;
  logic signed [DATA_WIDTH-1:0] hist_q [N];
  logic                         m_valid_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic                         err_q;

  logic                         accept;
  logic signed [DIFF_W-1:0]     diff;
  logic [HI_W-1:0]              diff_hi;
  logic                         ovf;
  logic signed [DATA_WIDTH-1:0] result;

  assign bus.s_ready = !m_valid_q || bus.m_ready;
  // A word arriving with flush is discarded even if s_ready is high.
  assign accept      = bus.s_valid && bus.s_ready && !flush;

  // Full-precision reconstruction and range check of the candidate sample.
  always_comb begin
    diff    = {{2{bus.s_sum[ACC_WIDTH-1]}}, bus.s_sum}
            - {{2{prev_q[ACC_WIDTH-1]}}, prev_q}
            + {{(DIFF_W - DATA_WIDTH){hist_q[N-1][DATA_WIDTH-1]}}, hist_q[N-1]};
    // In range only when every bit from the DATA_WIDTH sign bit upward agrees.
    diff_hi = diff[DIFF_W-1:DATA_WIDTH-1];
    ovf     = !((&diff_hi) || !(|diff_hi));
    result  = diff[DATA_WIDTH-1:0];
`ifdef MOVING_SUM_DECODER_SAT_EN
    if (ovf) begin
      result = diff[DIFF_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`endif
  end

  // Output register, sum/sample history and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      prev_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else if (flush) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      prev_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= result;
      prev_q    <= bus.s_sum;
      // History holds what was emitted, so the decoder tracks its own output.
      hist_q[0] <= result;
      for (int i = 1; i < N; i++) hist_q[i] <= hist_q[i-1];
      if (ovf) err_q <= 1'b1;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Warm-up state register and sample counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWarmup;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Count accepted words until the window is full; the counter then freezes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = StWarmup;
      count_d = '0;
    end else begin
      unique case (state_q)
        StWarmup: begin
          if (accept) begin
            count_d = count_q + 1'b1;
            if (count_q == LastCount) state_d = StSteady;
          end
        end
        StSteady: begin
        end
        default: begin
          state_d = StWarmup;
        end
      endcase
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign primed      = (state_q == StSteady);
  assign err         = err_q;

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Directed bench for moving_sum_decoder (n=3, DATA_WIDTH=16).
module tb_moving_sum_decoder;

`ifdef MOVING_SUM_DECODER_SAT_EN
  localparam int OvfExp = 32767;
`else
  localparam int OvfExp = -25536;
`endif

  logic clk;
  logic reset_n;
  logic flush;
  logic primed;
  logic err;

  int n_checks = 0;
  int n_fail   = 0;

  moving_sum_decoder_if #(.n(3), .DATA_WIDTH(16)) bus ();

  moving_sum_decoder #(.n(3), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus),
    .primed  (primed),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n     = 1'b0;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_sum   = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Present one word with m_ready high and advance one edge; sample 1 time unit later.
  task automatic push(input int sum);
    bus.s_valid = 1'b1;
    bus.s_sum   = 19'(sum);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid);
    end
    n_checks++;
    if (bus.m_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_m_data: got %0d want 0", $signed(bus.m_data));
    end
    n_checks++;
    if (primed !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: primed=%b err=%b want 0 0", primed, err);
    end
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_basic();
    int sums [4] = '{5, 12, 12, 12};
    int exps [4] = '{5, 7, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(sums[i]);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'(exps[i])) begin
        n_fail++;
        $display("FAIL basic[%0d]: valid=%b data=%0d want valid=1 data=%0d",
                 i, bus.m_valid, $signed(bus.m_data), exps[i]);
      end
      n_checks++;
      if (primed !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL basic_flags[%0d]: primed=%b err=%b want 0 0", i, primed, err);
      end
    end
    idle();
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      int s;
      logic want_primed;
      s = (i < 8) ? 100 * (i + 1) : 800;
      want_primed = (i >= 7);
      push(s);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd100) begin
        n_fail++;
        $display("FAIL constant[%0d]: valid=%b data=%0d want valid=1 data=100",
                 i, bus.m_valid, $signed(bus.m_data));
      end
      n_checks++;
      if (primed !== want_primed) begin
        n_fail++; $display("FAIL constant_primed[%0d]: got %b want %b", i, primed, want_primed);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int sums [2] = '{100, 150};
    int exps [2] = '{40, 50};
    do_reset();
    push(10);
    push(30);
    // Output now holds 20; stall the sink while the next word waits.
    bus.s_valid = 1'b1;
    bus.s_sum   = 19'd60;
    bus.m_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_s_ready_early: got %b want 0", bus.s_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 16'd20) begin
        n_fail++;
        $display("FAIL stall[%0d]: s_ready=%b valid=%b data=%0d want 0 1 20",
                 i, bus.s_ready, bus.m_valid, $signed(bus.m_data));
      end
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd30) begin
      n_fail++;
      $display("FAIL release: valid=%b data=%0d want 1 30", bus.m_valid, $signed(bus.m_data));
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.s_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_s_ready[%0d]: got %b want 1", i, bus.s_ready);
      end
      push(sums[i]);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'(exps[i])) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b data=%0d want 1 %0d",
                 i, bus.m_valid, $signed(bus.m_data), exps[i]);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    do_reset();
    push(40000);
    n_checks++;
    if (bus.m_data !== 16'(OvfExp) || err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: data=%0d err=%b want data=%0d err=1",
               $signed(bus.m_data), err, OvfExp);
    end
    push(40000);
    n_checks++;
    if (bus.m_data !== 16'd0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: data=%0d err=%b want data=0 err=1",
               $signed(bus.m_data), err);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push(40000);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_err: got %b want 1", err);
    end
    flush       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_sum   = 19'd999;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (bus.m_valid !== 1'b0 || err !== 1'b0 || primed !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%b err=%b primed=%b want 0 0 0",
               bus.m_valid, err, primed);
    end
    push(3);
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd3) begin
      n_fail++;
      $display("FAIL flush_first: valid=%b data=%0d want 1 3", bus.m_valid, $signed(bus.m_data));
    end
    push(3);
    n_checks++;
    if (bus.m_data !== 16'd0 || primed !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_second: data=%0d primed=%b err=%b want 0 0 0",
               $signed(bus.m_data), primed, err);
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    push(7);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    n_checks++;
    if (bus.m_valid !== 1'b1) begin
      n_fail++; $display("FAIL async_pre: valid=%b want 1", bus.m_valid);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'd0) begin
      n_fail++;
      $display("FAIL async_clear: valid=%b data=%0d want 0 0", bus.m_valid, $signed(bus.m_data));
    end
    #2;
    reset_n = 1'b1;
    push(9);
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd9 || primed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_after: valid=%b data=%0d primed=%b want 1 9 0",
               bus.m_valid, $signed(bus.m_data), primed);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_constant();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moving_sum_decoder.md
Name: moving_sum_decoder

Overview:
- Inverse of the team's boxcar moving-sum/average filter.
- Takes a stream of N-sample running sums S[k] and reconstructs the original samples: x[k] = S[k] − S[k−1] + x[k−N].
- Sits on the verification/replay side of the market-data pipeline. It recovers raw ticks from logged window sums and cross-checks the filter.
- Both streams use valid/ready handshakes with backpressure.

Parameters:
- n, 3, log2 of window length; N = 2^n samples.
- DATA_WIDTH, 16, signed width of reconstructed samples.
- ACC_WIDTH, DATA_WIDTH+n, signed width of the incoming sum (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of history, prev-sum, counters and err; wins over all other activity in that cycle.
- s_valid  in  1  sum word valid.
- s_ready  out  1  decoder can accept a sum word.
- s_sum  in  ACC_WIDTH  signed running sum S[k].
- m_valid  out  1  reconstructed sample valid.
- m_ready  in  1  downstream accepts the sample.
- m_data  out  DATA_WIDTH  signed reconstructed x[k].
- primed  out  1  high once N samples have been emitted since reset/flush.
- err  out  1  sticky: a reconstructed value did not fit DATA_WIDTH.

Behaviour:
- Reset (reset_n low, async):
  - Outputs: m_valid=0, m_data=0, primed=0, err=0.
  - State: prev_sum=0, hist[0..N−1]=0, count=0, state=WARMUP.
  - These zeros match the encoder's reset state, so decoding is exact from the first word.
- Handshake:
  - s_ready = !m_valid || m_ready. Single output register, no combinational path from s_valid to m_valid.
  - An input transfer occurs when s_valid && s_ready.
  - Output holds m_data/m_valid stable while m_valid && !m_ready.
- Latency: 1 cycle. A sum accepted at edge t gives m_valid=1 with its x from edge t onward.
- Arithmetic:
  - Full-precision diff = s_sum − prev_sum + sign-extended hist[N−1], computed in ACC_WIDTH+2 bits.
  - m_data = diff truncated to DATA_WIDTH (two's-complement wrap).
  - If diff lies outside [−2^(DW−1), 2^(DW−1)−1], err is set and stays high until flush or reset.
- Per accepted word:
  - prev_sum ← s_sum.
  - hist shifts: hist[i] ← hist[i−1], hist[0] ← m_data value (post-truncation/saturation).
- State machine:
  - WARMUP: count increments per accepted word. After the Nth accepted word, go to STEADY and set primed=1 (visible with that Nth sample).
  - STEADY: count is frozen; primed stays 1.
  - flush returns to WARMUP.
- Boundary conditions:
  - flush with s_valid high: the word is dropped (s_ready may be 1, but the transfer is discarded); m_valid←0.
  - flush while m_valid && !m_ready: the pending sample is discarded.
  - A simultaneous accept and output drain in one cycle must sustain 1 word/cycle throughput.
  - Mid-stream reset_n assertion: all state clears immediately; no partial output survives.
- Wrap: the count register is n+1 bits and never wraps, because it freezes in STEADY.

Optional Feature:
- Macro: MOVING_SUM_DECODER_SAT_EN.
- Defined: out-of-range diff saturates m_data to the DATA_WIDTH max/min. The saturated value enters hist. err is still set.
- Undefined: two's-complement wrap as above.

Test Plan:
- Reset then sums 5, 12, 12, 12 (n=3, DW=16) -> m_data 5, 7, 0, 0 at 1-cycle latency; primed=0, err=0.
- Constant x=100 encoded for 12 words (sums 100, 200, … 800, 800, 800, 800) -> m_data=100 for all 12; primed rises with the 8th sample.
- m_ready held low for 3 cycles while s_valid=1 -> s_ready=0, m_data held stable, no word lost; on release the following words stream at 1/cycle.
- Sum jump 0 -> 40000 with empty history -> err=1 sticky. Without the macro m_data=−25536; with the macro m_data=32767.
- flush asserted mid-stream after 5 words, then sums 3, 3 -> m_data 3, 0; primed=0, err cleared.
- reset_n pulsed low asynchronously mid-cycle while m_valid=1 -> m_valid=0 immediately; next sum 9 yields m_data=9.
